fetchbuffer: RTL and testbench
==============================

FETCHBUFFER -- requirements
Module: fetchbuffer

Interface
REQ-001 Parameter DEPTH, 8, halfword entries in buffer; power of two, >=4.
REQ-002 Port reset  input  1  asynchronous, active-low; buffer cleared while 0.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port fetchbuffer_in  input  mem_in_type  fetch request: mem_valid, mem_fence, mem_spec, mem_mode, mem_addr (halfword-aligned PC); mem_instr/wdata/wstrb ignored.
REQ-005 Port fetchbuffer_out  output  mem_out_type  fetch response: mem_ready, mem_error, mem_rdata[31:0].
REQ-006 Port imem_in  output  mem_in_type  word request to instruction memory.
REQ-007 Port imem_out  input  mem_out_type  instruction memory response: mem_ready, mem_error, mem_rdata.

Function
REQ-008 State: halfword FIFO (data[15:0] + error bit per entry), head tag address, tag_valid, one outstanding-request flag, drop flag, next word fetch address.
REQ-009 Fetch-side response is combinational from current state and fetchbuffer_in, same cycle.
REQ-010 Hit: mem_valid=1, mem_spec=0, mem_fence=0, tag_valid=1, mem_addr==head tag.
REQ-011 On hit, head low bits !=2'b11 (compressed) and count>=1: mem_ready=1, rdata={16'h0, head}.
REQ-012 On hit, head low bits ==2'b11 and count>=2: mem_ready=1, rdata={head+1, head}.
REQ-013 mem_error=1 instead of mem_ready when any consumed halfword carries error bit; rdata=0.
REQ-014 Otherwise mem_ready=0, mem_error=0, rdata=0.
REQ-015 Pop on mem_valid & (mem_ready|mem_error): remove 1 or 2 entries; head tag += 2 or 4.
REQ-016 Redirect: mem_valid=1 and (mem_spec=1 or mem_fence=1 or not hit-tag): flush FIFO, tag=mem_addr, tag_valid=1, fetch address=mem_addr & ~3, no response that cycle.
REQ-017 Redirect while request outstanding: set drop; next imem response discarded, then drop clears.
REQ-018 imem_in.mem_valid=1 when no request outstanding and free entries >=2; mem_addr=fetch address, mem_instr=1, mem_mode=fetchbuffer_in.mem_mode, mem_spec/fence/wdata/wstrb=0.
REQ-019 Redirect cycle may issue the new request in the same cycle (addr = new fetch address).
REQ-020 imem response (ready or error), not dropped: push two halfwords (low first); fetch address += 4.
REQ-021 First word after redirect with mem_addr[1]=1: push upper halfword only.
REQ-022 Response with mem_error=1: pushed entries carry error bit, rdata ignored.
REQ-023 Simultaneous pop and push in one cycle permitted; count = count - popped + pushed, never exceeds DEPTH.
REQ-024 FIFO pointers wrap modulo DEPTH.
REQ-025 mem_valid=0: no pop, no redirect; prefetch continues until full.

Reset
REQ-026 While reset=0: FIFO empty, tag_valid=0, outstanding=0, drop=0, fetch address=0.
REQ-027 Outputs during reset: fetchbuffer_out all 0, imem_in.mem_valid=0.
REQ-028 Reset mid-transfer: in-flight imem response after release ignored via drop=1 being not required; memory is reset together with block.

Configuration
REQ-029 Macro FETCHBUFFER_BYPASS_EN.
REQ-030 Defined: FIFO empty and imem response arriving with hit address -> response forwarded combinationally same cycle; unconsumed halfwords pushed.
REQ-031 Undefined: response always written to FIFO first; earliest fetch-side ready one cycle after imem_out.mem_ready.

Verification
REQ-032 Reset release, request addr 0x0, imem returns 0x00000013 one cycle later -> ready with rdata 0x00000013 next cycle (same cycle if bypass); imem requests 0x4 following.
REQ-033 Word 0x45014501 at 0x100, requests 0x100 then 0x102 -> two ready responses rdata 0x00004501, head tag 0x104.
REQ-034 Redirect to 0x202 (spec=1) with request outstanding -> outstanding response dropped, imem addr 0x200, first entry = upper halfword of 0x200 word.
REQ-035 32-bit instruction split across words 0x1FE/0x200 -> ready only after both words present, rdata {hw@0x200, hw@0x1FE}.
REQ-036 imem_out.mem_error=1 for 0x300 -> request 0x300 gets mem_error=1, mem_ready=0; mem_valid held 0 for 10 cycles -> FIFO fills to DEPTH, no further imem requests.

Source files
------------

// File: rtl/fetchbuffer.sv
// Halfword prefetch buffer between the fetch stage and instruction memory.
// Optional FETCHBUFFER_BYPASS_EN forwards an imem response straight to the fetch side when the buffer is empty.

package fetchbuffer_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

module fetchbuffer
  import fetchbuffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  fetchbuffer_in,
  output mem_out_type fetchbuffer_out,
  output mem_in_type  imem_in,
  input  mem_out_type imem_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [15:0]      data_q [DEPTH];
  logic             err_q  [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      tag_q;
  logic             tag_valid_q;
  logic             outstanding_q;
  logic             drop_q;
  logic             skip_low_q;
  logic [31:0]      fetch_addr_q;

  logic             hit_tag;
  logic             redirect;
  logic             rsp_in;
  logic             rsp_accept;
  logic [1:0]       inc_n;
  logic [15:0]      inc_hw0;
  logic [15:0]      inc_hw1;
  logic             inc_err;
  logic [15:0]      h0;
  logic [15:0]      h1;
  logic             e0;
  logic             e1;
  logic [CNT_W-1:0] avail;
  logic             bypass;
  logic             is32;
  logic [1:0]       need;
  logic             fire;
  logic             fire_err;
  logic [1:0]       pop_fifo;
  logic [1:0]       push_n;
  logic [15:0]      push_hw0;
  logic [15:0]      push_hw1;
  logic [CNT_W-1:0] free;
  logic             req_issue;
  logic [31:0]      req_addr;
  logic [PTR_W-1:0] rd_nxt;
  logic [PTR_W-1:0] wr_nxt;
  logic             unused_in;

  assign rd_nxt = rd_ptr_q + PTR_W'(1);
  assign wr_nxt = wr_ptr_q + PTR_W'(1);
  assign unused_in = &{1'b0, fetchbuffer_in.mem_instr, fetchbuffer_in.mem_wdata,
                       fetchbuffer_in.mem_wstrb};

  // Hit/redirect decode, incoming-halfword selection, pop/push sizing and both response ports
  always_comb begin
    hit_tag    = fetchbuffer_in.mem_valid & ~fetchbuffer_in.mem_spec & ~fetchbuffer_in.mem_fence
               & tag_valid_q & (fetchbuffer_in.mem_addr == tag_q);
    redirect   = fetchbuffer_in.mem_valid & ~hit_tag;
    rsp_in     = outstanding_q & (imem_out.mem_ready | imem_out.mem_error);
    rsp_accept = rsp_in & ~drop_q & ~redirect;
    inc_err    = imem_out.mem_error;
    inc_n      = 2'd0;
    inc_hw0    = 16'h0;
    inc_hw1    = 16'h0;
    // Error data is never trusted; a zeroed halfword decodes as a 16-bit slot
    if (rsp_accept) begin
      if (skip_low_q) begin
        inc_n   = 2'd1;
        inc_hw0 = inc_err ? 16'h0 : imem_out.mem_rdata[31:16];
      end else begin
        inc_n   = 2'd2;
        inc_hw0 = inc_err ? 16'h0 : imem_out.mem_rdata[15:0];
        inc_hw1 = inc_err ? 16'h0 : imem_out.mem_rdata[31:16];
      end
    end

    h0     = data_q[rd_ptr_q];
    h1     = data_q[rd_nxt];
    e0     = err_q[rd_ptr_q];
    e1     = err_q[rd_nxt];
    avail  = count_q;
    bypass = 1'b0;
`ifdef FETCHBUFFER_BYPASS_EN
    if ((count_q == '0) && rsp_accept) begin
      bypass = 1'b1;
      h0     = inc_hw0;
      h1     = inc_hw1;
      e0     = inc_err;
      e1     = inc_err;
      avail  = CNT_W'(inc_n);
    end
`endif

    is32     = (h0[1:0] == 2'b11);
    need     = is32 ? 2'd2 : 2'd1;
    fire     = hit_tag & (avail >= CNT_W'(need));
    fire_err = e0 | (is32 & e1);

    pop_fifo = 2'd0;
    push_n   = inc_n;
    push_hw0 = inc_hw0;
    push_hw1 = inc_hw1;
    // A bypassed response only leaves its unconsumed halfwords behind
    if (fire) begin
      if (bypass) begin
        push_n = inc_n - need;
        if (need == 2'd1) push_hw0 = inc_hw1;
      end else begin
        pop_fifo = need;
      end
    end

    free      = CNT_W'(DEPTH) - count_q;
    req_issue = ~outstanding_q & (redirect | (free >= CNT_W'(2)));
    req_addr  = redirect ? {fetchbuffer_in.mem_addr[31:2], 2'b00} : fetch_addr_q;

    fetchbuffer_out = '0;
    if (fire) begin
      if (fire_err) begin
        fetchbuffer_out.mem_error = 1'b1;
      end else begin
        fetchbuffer_out.mem_ready = 1'b1;
        fetchbuffer_out.mem_rdata = is32 ? {h1, h0} : {16'h0, h0};
      end
    end

    imem_in           = '0;
    imem_in.mem_valid = req_issue;
    imem_in.mem_addr  = req_addr;
    imem_in.mem_instr = 1'b1;
    imem_in.mem_mode  = fetchbuffer_in.mem_mode;

    if (!reset) begin
      fetchbuffer_out = '0;
      imem_in         = '0;
    end
  end

  // Control state: pointers, count, tag, fetch address, outstanding/drop tracking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      tag_q         <= '0;
      tag_valid_q   <= 1'b0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      skip_low_q    <= 1'b0;
      fetch_addr_q  <= '0;
    end else begin
      if (redirect) begin
        rd_ptr_q     <= '0;
        wr_ptr_q     <= '0;
        count_q      <= '0;
        tag_q        <= fetchbuffer_in.mem_addr;
        tag_valid_q  <= 1'b1;
        fetch_addr_q <= {fetchbuffer_in.mem_addr[31:2], 2'b00};
        skip_low_q   <= fetchbuffer_in.mem_addr[1];
      end else begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(pop_fifo);
        wr_ptr_q <= wr_ptr_q + PTR_W'(push_n);
        count_q  <= count_q - CNT_W'(pop_fifo) + CNT_W'(push_n);
        if (fire) tag_q <= tag_q + 32'({need, 1'b0});
        if (rsp_accept) begin
          fetch_addr_q <= fetch_addr_q + 32'd4;
          skip_low_q   <= 1'b0;
        end
      end

      if (req_issue)   outstanding_q <= 1'b1;
      else if (rsp_in) outstanding_q <= 1'b0;

      // A response arriving in the redirect cycle is discarded directly
      if (redirect)    drop_q <= outstanding_q & ~rsp_in;
      else if (rsp_in) drop_q <= 1'b0;
    end
  end

  // Halfword storage
  always_ff @(posedge clock) begin
    if (reset && !redirect && (push_n != 2'd0)) begin
      data_q[wr_ptr_q] <= push_hw0;
      err_q[wr_ptr_q]  <= inc_err;
      if (push_n == 2'd2) begin
        data_q[wr_nxt] <= push_hw1;
        err_q[wr_nxt]  <= inc_err;
      end
    end
  end

endmodule

// File: tb/tb_fetchbuffer.sv
// fetchbuffer bench: directed scenarios plus random fetch/imem traffic checked against an
// address-level model (buffer contents = halfwords between head tag and end of fetched words).
`timescale 1ns/1ps
module tb_fetchbuffer;
  import fetchbuffer_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  mem_in_type  fb_in;
  mem_out_type fb_out;
  mem_in_type  imem_req;
  mem_out_type imem_rsp;

  fetchbuffer #(.DEPTH(DEPTH)) dut (
    .reset          (reset),
    .clock          (clock),
    .fetchbuffer_in (fb_in),
    .fetchbuffer_out(fb_out),
    .imem_in        (imem_req),
    .imem_out       (imem_rsp)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // memory image: hashed words, a few fixed overrides, and word addresses that answer with error
  logic [31:0] ovr  [int unsigned];
  bit          errw [int unsigned];

  // reference state, all in byte addresses
  int unsigned m_tag, m_fend;
  bit          m_tv, m_out, m_drop;

  // imem responder
  bit          r_pend;
  int          r_wait;
  int unsigned r_addr;
  int          lat_lo = 1, lat_hi = 1;

  // values sampled in the last step
  bit          s_ready, s_error, s_ivalid, e_fire;
  logic [31:0] s_rdata, s_iaddr;
  int          e_need;
  bit          cap_arm, cap_seen;
  logic [31:0] cap_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input int unsigned a);
    int unsigned w;
    w = a & ~32'd3;
    if (ovr.exists(w)) return ovr[w];
    return (w * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  function automatic logic [15:0] hw(input int unsigned a);
    logic [31:0] w;
    if (errw.exists(a & ~32'd3)) return 16'h0;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic drive_imem();
    imem_rsp = '0;
    if (r_pend) begin
      r_wait--;
      if (r_wait == 0) begin
        r_pend = 1'b0;
        if (errw.exists(r_addr)) begin
          imem_rsp.mem_error = 1'b1;
          imem_rsp.mem_rdata = $urandom;
        end else begin
          imem_rsp.mem_ready = 1'b1;
          imem_rsp.mem_rdata = mem_word(r_addr);
        end
      end
    end
  endtask

  // one clock: compare both ports against the model at negedge, advance model, move to next cycle
  task automatic step();
    int          occ, avail;
    bit          hit, redir, rsp_in, accept, is32, fire, ferr, exp_req;
    int unsigned a;
    logic [31:0] exp_rdata;
    @(negedge clock);
    a      = fb_in.mem_addr;
    hit    = fb_in.mem_valid && !fb_in.mem_spec && !fb_in.mem_fence && m_tv && (a == m_tag);
    redir  = fb_in.mem_valid && !hit;
    rsp_in = m_out && (imem_rsp.mem_ready || imem_rsp.mem_error);
    accept = rsp_in && !m_drop && !redir;
    occ    = int'(m_fend - m_tag) / 2;
    if (occ < 0) occ = 0;
    avail  = occ;
`ifdef FETCHBUFFER_BYPASS_EN
    if (occ == 0 && accept) avail = int'(m_fend + 32'd4 - m_tag) / 2;
`endif
    is32      = (hw(m_tag) & 16'h3) == 16'h3;
    e_need    = is32 ? 2 : 1;
    fire      = hit && (avail >= e_need);
    ferr      = errw.exists(m_tag & ~32'd3) || (is32 && errw.exists((m_tag + 32'd2) & ~32'd3));
    exp_rdata = is32 ? {hw(m_tag + 32'd2), hw(m_tag)} : {16'h0, hw(m_tag)};
    exp_req   = !m_out && (redir || occ <= int'(DEPTH) - 2);

    check("fb_ready", 32'(fb_out.mem_ready), 32'(fire && !ferr));
    check("fb_error", 32'(fb_out.mem_error), 32'(fire && ferr));
    check("fb_rdata", fb_out.mem_rdata, (fire && !ferr) ? exp_rdata : 32'h0);
    check("imem_valid", 32'(imem_req.mem_valid), 32'(exp_req));
    if (exp_req && imem_req.mem_valid) begin
      check("imem_addr", imem_req.mem_addr, redir ? (a & ~32'd3) : m_fend);
      check("imem_ctl",
            {28'h0, imem_req.mem_instr, imem_req.mem_mode,
             imem_req.mem_spec | imem_req.mem_fence | (|imem_req.mem_wstrb) | (|imem_req.mem_wdata)},
            {28'h0, 1'b1, fb_in.mem_mode, 1'b0});
    end

    s_ready  = fb_out.mem_ready;
    s_error  = fb_out.mem_error;
    s_rdata  = fb_out.mem_rdata;
    s_ivalid = imem_req.mem_valid;
    s_iaddr  = imem_req.mem_addr;
    e_fire   = fire;
    if (cap_arm && !cap_seen && imem_req.mem_valid) begin
      cap_seen = 1'b1;
      cap_addr = imem_req.mem_addr;
    end

    if (redir) begin
      m_tag  = a;
      m_tv   = 1'b1;
      m_fend = a & ~32'd3;
    end else if (fire) begin
      m_tag = m_tag + 32'(e_need * 2);
    end
    if (accept) m_fend = m_fend + 32'd4;
    if (redir)       m_drop = m_out && !rsp_in;
    else if (rsp_in) m_drop = 1'b0;
    if (exp_req)     m_out = 1'b1;
    else if (rsp_in) m_out = 1'b0;
    if (imem_req.mem_valid) begin
      r_pend = 1'b1;
      r_addr = imem_req.mem_addr;
      r_wait = $urandom_range(lat_lo, lat_hi);
    end

    @(posedge clock);
    #1;
    drive_imem();
  endtask

  task automatic run_fetch(input logic [31:0] addr, input bit spec,
                           output bit r, output bit e, output logic [31:0] d);
    int n;
    n = 0;
    fb_in.mem_valid = 1'b1;
    fb_in.mem_addr  = addr;
    fb_in.mem_spec  = spec;
    fb_in.mem_fence = 1'b0;
    do begin
      step();
      fb_in.mem_spec = 1'b0;
      n++;
    end while (!e_fire && n < 60);
    check("fetch_done", 32'(e_fire), 32'd1);
    r = s_ready;
    e = s_error;
    d = s_rdata;
    fb_in.mem_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    fb_in.mem_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    fb_in.mem_valid    = 1'b1;
    fb_in.mem_addr     = 32'h40;
    imem_rsp           = '0;
    imem_rsp.mem_ready = 1'b1;
    r_pend             = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("rst_fb_flags", {30'h0, fb_out.mem_ready, fb_out.mem_error}, 32'h0);
      check("rst_fb_rdata", fb_out.mem_rdata, 32'h0);
      check("rst_imem_valid", 32'(imem_req.mem_valid), 32'h0);
    end
    m_tag  = 0;
    m_fend = 0;
    m_tv   = 1'b0;
    m_out  = 1'b0;
    m_drop = 1'b0;
    @(posedge clock);
    #1;
    imem_rsp = '0;
    fb_in    = '0;
    reset    = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          r, e;
    logic [31:0] d;
    int unsigned pc;
    bit          jump;

    fb_in    = '0;
    imem_rsp = '0;
    reset    = 1'b0;
    cap_arm  = 1'b0;
    cap_seen = 1'b0;
    ovr[32'h0]   = 32'h0000_0013;
    ovr[32'h100] = 32'h4501_4501;
    ovr[32'h1FC] = 32'h0093_4501;
    ovr[32'h200] = 32'h4585_00A1;
    errw[32'h300] = 1'b1;
    @(posedge clock);
    #1;
    do_reset();

    // first fetch after reset at 0x0
    fb_in.mem_valid = 1'b1;
    fb_in.mem_addr  = 32'h0;
    step();
    check("r0_req_valid", 32'(s_ivalid), 32'd1);
    check("r0_req_addr", s_iaddr, 32'h0);
    step();
`ifdef FETCHBUFFER_BYPASS_EN
    check("r0_ready", 32'(s_ready), 32'd1);
    check("r0_rdata", s_rdata, 32'h0000_0013);
    fb_in.mem_valid = 1'b0;
    step();
`else
    check("r0_early", 32'(s_ready), 32'd0);
    step();
    check("r0_ready", 32'(s_ready), 32'd1);
    check("r0_rdata", s_rdata, 32'h0000_0013);
`endif
    check("r0_next_valid", 32'(s_ivalid), 32'd1);
    check("r0_next_addr", s_iaddr, 32'h4);
    fb_in.mem_valid = 1'b0;

    // two compressed instructions in one word
    run_fetch(32'h100, 1'b0, r, e, d);
    check("c100_ready", 32'(r), 32'd1);
    check("c100_rdata", d, 32'h0000_4501);
    run_fetch(32'h102, 1'b0, r, e, d);
    check("c102_ready", 32'(r), 32'd1);
    check("c102_rdata", d, 32'h0000_4501);
    run_fetch(32'h104, 1'b0, r, e, d);
    check("c104_ready", 32'(r), 32'd1);
    idle(20);
    check("full_no_req", 32'(s_ivalid), 32'd0);

    // speculative redirect to 0x202 while 0x400 is in flight
    lat_lo = 3;
    lat_hi = 3;
    fb_in.mem_valid = 1'b1;
    fb_in.mem_addr  = 32'h400;
    fb_in.mem_spec  = 1'b1;
    step();
    check("r400_req_valid", 32'(s_ivalid), 32'd1);
    check("r400_req_addr", s_iaddr, 32'h400);
    cap_arm  = 1'b1;
    cap_seen = 1'b0;
    run_fetch(32'h202, 1'b1, r, e, d);
    cap_arm = 1'b0;
    check("r202_req_addr", cap_addr, 32'h200);
    check("r202_ready", 32'(r), 32'd1);
    check("r202_rdata", d, 32'h0000_4585);

    // 32-bit instruction straddling 0x1FE/0x200
    run_fetch(32'h1FE, 1'b0, r, e, d);
    check("s1fe_ready", 32'(r), 32'd1);
    check("s1fe_rdata", d, 32'h00A1_0093);

    // error word at 0x300, then let the buffer fill
    lat_lo = 1;
    lat_hi = 1;
    run_fetch(32'h300, 1'b1, r, e, d);
    check("e300_error", 32'(e), 32'd1);
    check("e300_ready", 32'(r), 32'd0);
    check("e300_rdata", d, 32'h0);
    idle(10);
    check("e_full_no_req", 32'(s_ivalid), 32'd0);
    run_fetch(32'h302, 1'b0, r, e, d);
    check("e302_error", 32'(e), 32'd1);
    run_fetch(32'h304, 1'b0, r, e, d);
    check("e304_ready", 32'(r), 32'd1);

    // random traffic with variable imem latency and scattered error words
    lat_lo = 1;
    lat_hi = 3;
    for (int i = 0; i < 6; i++) errw[32'h1000 + 32'(4 * $urandom_range(0, 63))] = 1'b1;
    pc = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      jump = ($urandom_range(0, 19) == 0);
      if (jump) pc = 32'h1000 + 32'(2 * $urandom_range(0, 127));
      if (pc > 32'h1200) pc = 32'h1000;
      fb_in.mem_valid = ($urandom_range(0, 9) != 0);
      fb_in.mem_addr  = pc;
      fb_in.mem_spec  = jump && ($urandom_range(0, 1) == 1);
      fb_in.mem_fence = ($urandom_range(0, 49) == 0);
      fb_in.mem_mode  = 2'($urandom_range(0, 3));
      fb_in.mem_instr = 1'($urandom_range(0, 1));
      fb_in.mem_wdata = $urandom;
      fb_in.mem_wstrb = 4'($urandom_range(0, 15));
      step();
      if (e_fire) pc = pc + 32'(e_need * 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
